// File: rtl/sync_stat_pkg.sv
// rtl/sync_stat_pkg.sv - shared widths, flag indices and status word layout for sync_stat_irq
package sync_stat_pkg;

  localparam int C_LINE_W_DFLT = 10;
  localparam int C_HPER_W_DFLT = 12;
  localparam int C_FLD_W_DFLT  = 4;

  localparam int N_FLG    = 3;
  localparam int FLG_VD   = 0;
  localparam int FLG_HD   = 1;
  localparam int FLG_LCMP = 2;

  localparam int STAT_VD_BIT   = 15;
  localparam int STAT_HD_BIT   = 14;
  localparam int STAT_LCMP_BIT = 13;
  localparam int STAT_LINE_LSB = 0;

endpackage

// File: rtl/sync_fall_det.sv
// rtl/sync_fall_det.sv - double register of an active-low strobe with a registered falling-edge pulse
module sync_fall_det (
  input  logic ck,
  input  logic rst_n,
  input  logic strobe_n,
  output logic fall
);

  logic q;
  logic qq;

  // Both stages reset high so a strobe that is already low at release is not mistaken for an edge.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      q    <= 1'b1;
      qq   <= 1'b1;
      fall <= 1'b0;
    end else begin
      q    <= strobe_n;
      qq   <= q;
      fall <= qq & ~q;
    end
  end

endmodule

// File: rtl/sync_stat_irq.sv
// rtl/sync_stat_irq.sv - XHD/XVD timing measurement with sticky, toggle-acknowledged interrupt flags
module sync_stat_irq
  import sync_stat_pkg::*;
#(
  parameter int C_LINE_W = C_LINE_W_DFLT,
  parameter int C_HPER_W = C_HPER_W_DFLT,
  parameter int C_FLD_W  = C_FLD_W_DFLT
) (
  input  logic                CK_i,
  input  logic                XSYS_R_i,
  input  logic                XHD_i,
  input  logic                XVD_i,
  input  logic [C_LINE_W-1:0] LINE_CMP_i,
  input  logic [2:0]          IRQ_EN_i,
  input  logic [2:0]          ACK_i,
  output logic [15:0]         DB_STAT_o,
  output logic [15:0]         DB_MEAS_o,
  output logic [15:0]         DB_LPF_o,
  output logic                IRQ_o
);

  localparam logic [C_HPER_W-1:0] PCLK_MAX = '1;
  localparam logic [C_LINE_W-1:0] LINE_MAX = '1;

  logic                hd_fall;
  logic                vd_fall;
  logic [C_HPER_W-1:0] pclk_ctr;
  logic [C_HPER_W-1:0] hd_period;
  logic                hd_seen;
  logic [C_LINE_W-1:0] line_ctr;
  logic [C_LINE_W-1:0] line_nxt;
  logic [C_LINE_W-1:0] lpf;
  logic [C_FLD_W-1:0]  field_ctr;
  logic [N_FLG-1:0]    flag;
  logic [N_FLG-1:0]    flag_set;
  logic [N_FLG-1:0]    flag_clr;
  logic [N_FLG-1:0]    ack_s;
  logic                irq;

  sync_fall_det u_hd_det (.ck(CK_i), .rst_n(XSYS_R_i), .strobe_n(XHD_i), .fall(hd_fall));
  sync_fall_det u_vd_det (.ck(CK_i), .rst_n(XSYS_R_i), .strobe_n(XVD_i), .fall(vd_fall));

  always_comb begin
    line_nxt = line_ctr;
    if (vd_fall) begin
      line_nxt = '0;
    end else if (hd_fall && (line_ctr != LINE_MAX)) begin
      line_nxt = line_ctr + 1'b1;
    end
    // Line compare looks at the value the counter is about to take, so line 0 after VD can match.
    flag_set           = '0;
    flag_set[FLG_VD]   = vd_fall;
    flag_set[FLG_HD]   = hd_fall;
    flag_set[FLG_LCMP] = (hd_fall | vd_fall) && (line_nxt == LINE_CMP_i);
    flag_clr           = ACK_i ^ ack_s;
  end

  always_ff @(posedge CK_i or negedge XSYS_R_i) begin
    if (!XSYS_R_i) begin
      pclk_ctr  <= '0;
      hd_period <= '0;
      hd_seen   <= 1'b0;
      line_ctr  <= '0;
      lpf       <= '0;
      field_ctr <= '0;
      flag      <= '0;
      ack_s     <= '0;
      irq       <= 1'b0;
    end else begin
      ack_s    <= ACK_i;
      flag     <= (flag & ~flag_clr) | flag_set;
      irq      <= |(flag & IRQ_EN_i);
      line_ctr <= line_nxt;
      // The first HD fall only starts the period count; the count since reset is meaningless.
      if (hd_fall) begin
        if (hd_seen) begin
          hd_period <= pclk_ctr;
        end
        hd_seen  <= 1'b1;
        pclk_ctr <= C_HPER_W'(1);
      end else if (pclk_ctr != PCLK_MAX) begin
        pclk_ctr <= pclk_ctr + 1'b1;
      end
      if (vd_fall) begin
        lpf       <= line_ctr;
        field_ctr <= field_ctr + 1'b1;
      end
    end
  end

  always_comb begin
    DB_STAT_o                                     = '0;
    DB_STAT_o[STAT_VD_BIT]                        = flag[FLG_VD];
    DB_STAT_o[STAT_HD_BIT]                        = flag[FLG_HD];
    DB_STAT_o[STAT_LCMP_BIT]                      = flag[FLG_LCMP];
    DB_STAT_o[STAT_LINE_LSB +: C_LINE_W]          = line_ctr;
    DB_MEAS_o                                     = 16'({field_ctr, hd_period});
    DB_LPF_o                                      = 16'(lpf);
    IRQ_o                                         = irq;
  end

endmodule

// File: tb/tb_sync_stat_irq.sv
// tb/tb_sync_stat_irq.sv - scoreboard bench for sync_stat_irq
module tb_sync_stat_irq;

  logic        clk;
  logic        rst_n;
  logic        xhd;
  logic        xvd;
  logic [9:0]  line_cmp;
  logic [2:0]  irq_en;
  logic [2:0]  ack;
  logic [15:0] db_stat;
  logic [15:0] db_meas;
  logic [15:0] db_lpf;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];

  sync_stat_irq dut (
    .CK_i      (clk),
    .XSYS_R_i  (rst_n),
    .XHD_i     (xhd),
    .XVD_i     (xvd),
    .LINE_CMP_i(line_cmp),
    .IRQ_EN_i  (irq_en),
    .ACK_i     (ack),
    .DB_STAT_o (db_stat),
    .DB_MEAS_o (db_meas),
    .DB_LPF_o  (db_lpf),
    .IRQ_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic push_all(input string tag, input logic [15:0] stat, input logic [15:0] meas,
                          input logic [15:0] lpf, input logic irq_exp);
    push_one({tag, ".stat"}, 0, stat);
    push_one({tag, ".meas"}, 1, meas);
    push_one({tag, ".lpf"}, 2, lpf);
    push_one({tag, ".irq"}, 3, {15'd0, irq_exp});
  endtask

  task automatic sb_drain();
    exp_t        e;
    logic [15:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       obs = db_stat;
        1:       obs = db_meas;
        2:       obs = db_lpf;
        default: obs = {15'd0, irq};
      endcase
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hd_pulses(input int count, input int period, input int width);
    for (int i = 0; i < count; i++) begin
      xhd = 1'b0;
      step(width);
      xhd = 1'b1;
      step(period - width);
    end
  endtask

  task automatic vd_pulse();
    xvd = 1'b0;
    step(4);
    xvd = 1'b1;
    step(16);
  endtask

  initial begin
    rst_n    = 1'b0;
    xhd      = 1'b1;
    xvd      = 1'b1;
    line_cmp = 10'd1023;
    irq_en   = 3'b000;
    ack      = 3'b000;

    push_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    step(2);
    sb_drain();
    rst_n = 1'b1;
    push_all("idle", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    step(5);
    sb_drain();

    // Line period: first fall leaves the period at 0, second reports the spacing.
    push_all("hd1", 16'h4001, 16'h0000, 16'h0000, 1'b0);
    hd_pulses(1, 910, 64);
    sb_drain();
    push_all("hd2", 16'h4002, 16'd910, 16'h0000, 1'b0);
    hd_pulses(1, 910, 64);
    sb_drain();
    step(5000);
    push_all("hd_sat", 16'h4003, 16'h0FFF, 16'h0000, 1'b0);
    hd_pulses(1, 20, 4);
    sb_drain();

    push_all("vd1", 16'hC000, 16'h1FFF, 16'd3, 1'b0);
    vd_pulse();
    sb_drain();
    hd_pulses(262, 20, 4);
    push_all("vd262", 16'hC000, 16'h2014, 16'd262, 1'b0);
    vd_pulse();
    sb_drain();
    for (int i = 0; i < 13; i++) vd_pulse();
    push_all("fld15", 16'hC000, 16'hF014, 16'h0000, 1'b0);
    sb_drain();
    push_all("fld_wrap", 16'hC000, 16'h0014, 16'h0000, 1'b0);
    vd_pulse();
    sb_drain();

    // Line compare interrupt and its toggle acknowledge.
    line_cmp = 10'd100;
    irq_en   = 3'b100;
    hd_pulses(99, 20, 4);
    xhd = 1'b0;
    push_all("lcmp_set", 16'hE064, 16'h0014, 16'h0000, 1'b0);
    step(3);
    sb_drain();
    push_one("lcmp_irq", 3, 16'h0001);
    step(1);
    sb_drain();
    xhd = 1'b1;
    step(16);
    ack = 3'b100;
    push_one("lcmp_clr.stat", 0, 16'hC064);
    push_one("lcmp_clr.irq_lag", 3, 16'h0001);
    step(1);
    sb_drain();
    push_one("lcmp_clr.irq", 3, 16'h0000);
    step(1);
    sb_drain();

    // Acknowledge landing on the same clock as an HD fall: set wins.
    xhd = 1'b0;
    step(2);
    ack = 3'b110;
    push_one("ack_hd_same.stat", 0, 16'hC065);
    push_one("ack_hd_same.meas", 1, 16'h0016);
    step(1);
    sb_drain();
    xhd = 1'b1;
    step(10);
    ack = 3'b100;
    push_one("ack_hd_later.stat", 0, 16'h8065);
    step(1);
    sb_drain();
    step(16);

    // Coincident HD and VD falls.
    xhd = 1'b0;
    xvd = 1'b0;
    push_all("hd_vd", 16'hC000, 16'h101E, 16'd101, 1'b0);
    step(3);
    sb_drain();
    xhd = 1'b1;
    xvd = 1'b1;
    hd_pulses(2, 20, 4);

    rst_n = 1'b0;
    push_all("mid_reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    #1;
    sb_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
